store_buffer: RTL and testbench

//   Store-side data path between the MEM stage and data memory.
//   - Takes a store (sl_type = `MEM_SB / `MEM_SH / `MEM_SW, plus addr and wdata) and aligns its data into byte lanes.
//   - Generates the byte strobes and queues the store in a DEPTH-entry FIFO.
//   - Drains queued stores to memory over a valid/ready handshake.
//   - Flags loads whose word address matches any queued store (ld_hazard) so the pipeline can stall.

---
 rtl/store_buffer_if.sv | 49 ++++
 rtl/store_buffer.sv | 100 ++++++++++
 tb/tb_store_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store buffer handshake bundle: pipeline-side store/load-probe signals and memory-side drain port.
// Also provides the shared MEM_* access codes when the pipeline has not defined them already.
`ifndef MEM_NOP
`define MEM_NOP 4'h0
`endif
`ifndef MEM_LB
`define MEM_LB  4'h1
`endif
`ifndef MEM_LH
`define MEM_LH  4'h2
`endif
`ifndef MEM_LW
`define MEM_LW  4'h3
`endif
`ifndef MEM_SB
`define MEM_SB  4'h8
`endif
`ifndef MEM_SH
`define MEM_SH  4'h9
`endif
`ifndef MEM_SW
`define MEM_SW  4'hA
`endif

interface store_buffer_if #(parameter int DEPTH = 4);
  logic                     st_valid;
  logic                     st_ready;
  logic [3:0]               sl_type;
  logic [31:0]              addr;
  logic [31:0]              wdata;
  logic [31:0]              ld_addr;
  logic                     ld_hazard;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;
  logic [3:0]               mem_wstrb;
  logic [$clog2(DEPTH):0]   count;
  logic                     misalign;

  modport master (
    output st_valid, sl_type, addr, wdata, ld_addr, mem_ready,
    input  st_ready, ld_hazard, mem_valid, mem_addr, mem_wdata, mem_wstrb, count, misalign
  );
  modport slave (
    input  st_valid, sl_type, addr, wdata, ld_addr, mem_ready,
    output st_ready, ld_hazard, mem_valid, mem_addr, mem_wdata, mem_wstrb, count, misalign
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: lane-aligns stores, queues them in a DEPTH-entry FIFO, drains over valid/ready,
// and flags loads hitting a queued word. Optional misalignment rejection via STORE_MISALIGN_CHECK_EN.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  strb;
  } sb_entry_t;

  sb_entry_t        ent_q [DEPTH];
  sb_entry_t        ent_d;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             is_store, mis, enq, deq;
  logic [DEPTH-1:0] hit;

  always_comb begin
    is_store   = 1'b0;
    ent_d      = '0;
    ent_d.waddr = bus.addr[31:2];
    ent_d.data  = bus.wdata;
    ent_d.strb  = 4'b1111;
    case (bus.sl_type)
      `MEM_SB: begin
        is_store   = 1'b1;
        ent_d.data = {4{bus.wdata[7:0]}};
        ent_d.strb = 4'b0001 << bus.addr[1:0];
      end
      `MEM_SH: begin
        is_store   = 1'b1;
        ent_d.data = {2{bus.wdata[15:0]}};
        ent_d.strb = 4'b0011 << {bus.addr[1], 1'b0};
      end
      `MEM_SW: is_store = 1'b1;
      default: is_store = 1'b0;
    endcase
  end

`ifdef STORE_MISALIGN_CHECK_EN
  // Misaligned stores complete the handshake but are dropped instead of queued.
  assign mis = ((bus.sl_type == `MEM_SH) && bus.addr[0]) ||
               ((bus.sl_type == `MEM_SW) && (bus.addr[1:0] != 2'b00));
  assign bus.misalign = bus.st_valid & bus.st_ready & mis;
`else
  assign mis          = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  assign bus.st_ready = (cnt != CW'(DEPTH));
  assign enq          = bus.st_valid & bus.st_ready & is_store & ~mis;
  assign deq          = (cnt != '0) & bus.mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload needs no reset; occupancy is tracked entirely by pointers and count.
  always_ff @(posedge clk) begin
    if (enq) ent_q[wr_ptr] <= ent_d;
  end

  assign bus.mem_valid = (cnt != '0);
  assign bus.mem_addr  = {ent_q[rd_ptr].waddr, 2'b00};
  assign bus.mem_wdata = ent_q[rd_ptr].data;
  assign bus.mem_wstrb = ent_q[rd_ptr].strb;
  assign bus.count     = cnt;

  // An entry is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [PW-1:0] off;
    assign off    = PW'(i) - rd_ptr;
    assign hit[i] = ({1'b0, off} < cnt) && (ent_q[i].waddr == bus.ld_addr[31:2]);
  end

  assign bus.ld_hazard = |hit;

  logic unused_ld_lsb;
  assign unused_ld_lsb = ^bus.ld_addr[1:0];
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus pushes expected memory beats, a negedge monitor pops and compares.
`ifndef MEM_NOP
`define MEM_NOP 4'h0
`endif
`ifndef MEM_LW
`define MEM_LW  4'h3
`endif
`ifndef MEM_SB
`define MEM_SB  4'h8
`endif
`ifndef MEM_SH
`define MEM_SH  4'h9
`endif
`ifndef MEM_SW
`define MEM_SW  4'hA
`endif

module tb_store_buffer;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  beat_t sb[$];

  store_buffer_if #(.DEPTH(4)) bus ();
  store_buffer #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a beat transfers at the next posedge when valid & ready hold at this negedge.
  always @(negedge clk) begin
    if (rst_n && bus.mem_valid && bus.mem_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL beat: unexpected beat addr 0x%08h", bus.mem_addr);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== e) begin
          fails++;
          $display("FAIL beat: got %h/%h/%b expected %h/%h/%b",
                   bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, e.addr, e.data, e.strb);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic put(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = 1'b1;
    bus.sl_type  = t;
    bus.addr     = a;
    bus.wdata    = d;
  endtask

  task automatic idle();
    bus.st_valid = 1'b0;
    bus.sl_type  = `MEM_NOP;
  endtask

  task automatic drain();
    int n = 0;
    bus.mem_ready = 1'b1;
    while (bus.count != 0 && n < 20) begin
      cyc();
      n++;
    end
    chk("drain_empty", 32'(bus.count), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.st_valid = 1'b0; bus.sl_type = `MEM_NOP; bus.addr = '0; bus.wdata = '0;
    bus.ld_addr = '0; bus.mem_ready = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    smp();
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_count",     32'(bus.count),     32'd0);
    chk("rst_hazard",    32'(bus.ld_hazard), 32'd0);
    chk("rst_st_ready",  32'(bus.st_ready),  32'd1);

    // 1: SB at 0x103 goes straight through
    cyc();
    bus.mem_ready = 1'b1;
    put(`MEM_SB, 32'h103, 32'h1234_5678);
    sb.push_back({32'h100, 32'h7878_7878, 4'b1000});
    cyc(); idle();
    smp();
    chk("t1_mem_valid", 32'(bus.mem_valid), 32'd1);
    cyc(); smp();
    chk("t1_count", 32'(bus.count), 32'd0);

    // 2: SH then SW held back, then drained in order
    cyc();
    bus.mem_ready = 1'b0;
    put(`MEM_SH, 32'h202, 32'hABCD_EF01);
    sb.push_back({32'h200, 32'hEF01_EF01, 4'b1100});
    cyc();
    put(`MEM_SW, 32'h204, 32'hDEAD_BEEF);
    sb.push_back({32'h204, 32'hDEAD_BEEF, 4'b1111});
    cyc(); idle();
    smp();
    chk("t2_count", 32'(bus.count), 32'd2);
    chk("t2_wdata", bus.mem_wdata, 32'hEF01_EF01);
    chk("t2_wstrb", 32'(bus.mem_wstrb), 32'b1100);
    cyc();
    drain();

    // non-store codes never enqueue
    put(`MEM_LW, 32'h500, 32'h0);
    cyc(); idle(); smp();
    chk("load_no_enq", 32'(bus.count), 32'd0);

    // 3: fill, fifth rejected, one pop reopens
    cyc();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(`MEM_SW, 32'h10 * (i + 1), 32'hA0 + i);
      sb.push_back({32'h10 * (i + 1), 32'hA0 + i, 4'b1111});
      cyc();
    end
    idle(); smp();
    chk("t3_full_ready", 32'(bus.st_ready), 32'd0);
    chk("t3_full_count", 32'(bus.count), 32'd4);
    cyc();
    put(`MEM_SW, 32'h50, 32'hFF);
    bus.mem_ready = 1'b1;
    cyc(); idle();
    bus.mem_ready = 1'b0;
    smp();
    chk("t3_reopen_ready", 32'(bus.st_ready), 32'd1);
    chk("t3_after_pop",    32'(bus.count),    32'd3);
    cyc();
    drain();

    // 4: load hazard
    bus.mem_ready = 1'b0;
    bus.ld_addr = 32'h300;
    put(`MEM_SW, 32'h300, 32'h1122_3344);
    sb.push_back({32'h300, 32'h1122_3344, 4'b1111});
    smp();
    chk("t4_same_cycle", 32'(bus.ld_hazard), 32'd0);
    cyc(); idle();
    bus.ld_addr = 32'h302;
    smp();
    chk("t4_hit", 32'(bus.ld_hazard), 32'd1);
    cyc();
    bus.ld_addr = 32'h304;
    smp();
    chk("t4_miss", 32'(bus.ld_hazard), 32'd0);
    cyc();
    drain();
    bus.ld_addr = 32'h302;
    smp();
    chk("t4_after_drain", 32'(bus.ld_hazard), 32'd0);

    // 5: streaming with wrap, then reset mid-stream
    cyc();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      put(`MEM_SW, 32'h600 + 4 * i, 32'(i));
      sb.push_back({32'h600 + 4 * i, 32'(i), 4'b1111});
      cyc();
      if (i == 5) begin
        smp();
        chk("t5_count_steady", 32'(bus.count), 32'd1);
      end
    end
    idle();
    cyc(); smp();
    chk("t5_stream_drained", 32'(bus.count), 32'd0);
    cyc();
    bus.mem_ready = 1'b0;
    put(`MEM_SW, 32'h700, 32'h1);
    cyc();
    put(`MEM_SW, 32'h704, 32'h2);
    cyc(); idle();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    sb.delete();
    cyc();
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    smp();
    chk("t5_rst_valid", 32'(bus.mem_valid), 32'd0);
    chk("t5_rst_count", 32'(bus.count),     32'd0);

    // 6: misaligned word store
    cyc();
    put(`MEM_SW, 32'h401, 32'hCAFE_F00D);
`ifdef STORE_MISALIGN_CHECK_EN
    smp();
    chk("t6_misalign", 32'(bus.misalign), 32'd1);
    cyc(); idle(); smp();
    chk("t6_count", 32'(bus.count), 32'd0);
`else
    sb.push_back({32'h400, 32'hCAFE_F00D, 4'b1111});
    smp();
    chk("t6_misalign", 32'(bus.misalign), 32'd0);
    cyc(); idle(); smp();
    chk("t6_addr", bus.mem_addr, 32'h400);
    chk("t6_strb", 32'(bus.mem_wstrb), 32'b1111);
    cyc();
    drain();
`endif

    cyc(); cyc();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
